// File: rtl/frame_unpacker.sv
// frame_unpacker: reassembles MSB-first beats into a frame, checks markers, presents abc/def with error flag.
module frame_unpacker #(
  parameter int DEF_W = 32,
  parameter int IN_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_abc,
  output logic [DEF_W-1:0] o_def,
  output logic             o_err,
  output logic [7:0]       o_errCount
);
  localparam int FW     = DEF_W + 29;
  localparam int NBEATS = (FW + IN_W - 1) / IN_W;
  localparam int SW     = NBEATS * IN_W;
  localparam int CW     = $clog2(NBEATS + 1);
  typedef enum logic {COLLECT, PRESENT} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic abc_q, abc_d, err_q, err_d, accept, last, bad;
  logic [DEF_W-1:0] def_q, def_d;
  logic [7:0] ec_q, ec_d;
  always_comb begin
    accept  = state_q == COLLECT && i_valid;
    last    = accept && cnt_q == CW'(NBEATS - 1);
    sr_d    = accept ? SW'({sr_q, i_data}) : sr_q;
    cnt_d   = last ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
    // fields are decoded from the shift value including the beat arriving this cycle
    bad     = sr_d[DEF_W+27:DEF_W+16] != 12'h345 || sr_d[15:0] != 16'h3456;
    abc_d   = last ? sr_d[DEF_W+28] : abc_q;
    def_d   = last ? sr_d[DEF_W+15:16] : def_q;
    err_d   = last ? bad : err_q;
    ec_d    = last && bad && ec_q != 8'hFF ? ec_q + 8'd1 : ec_q;
    state_d = last ? PRESENT : (state_q == PRESENT && i_ready) ? COLLECT : state_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= COLLECT;
      sr_q    <= '0;
      cnt_q   <= '0;
      abc_q   <= 1'b0;
      def_q   <= '0;
      err_q   <= 1'b0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      def_q   <= def_d;
      err_q   <= err_d;
      ec_q    <= ec_d;
    end
  end
  assign o_ready    = state_q == COLLECT;
  assign o_valid    = state_q == PRESENT;
  assign o_abc      = abc_q;
  assign o_def      = def_q;
  assign o_err      = err_q;
  assign o_errCount = ec_q;
endmodule

// File: doc/frame_unpacker.md
# frame_unpacker

Receive-side counterpart of the fixed-format field packer. It accepts a packed frame as a stream of narrow beats, MSB-first, over a valid/ready handshake. It reassembles the frame, checks the two constant marker fields (12'h345 and 16'h3456), and presents the 1-bit flag and DEF_W-bit data field on a registered valid/ready output with an error flag. It sits between the serial link receiver and the consumer of decoded fields.

## Interface
- DEF_W, 32, width of the data field; 1..64
- IN_W, 8, input beat width; DEF_W+29 need not be a multiple of IN_W
- NBEATS, ceil((DEF_W+29)/IN_W) (derived localparam), beats per frame
- i_clk  input  1  clock; all logic on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_data  input  IN_W  frame beat, MSB-first
- i_valid  input  1  beat valid
- o_ready  output  1  unpacker accepts a beat this cycle
- o_valid  output  1  decoded frame available
- i_ready  input  1  consumer accepts decoded frame
- o_abc  output  1  flag field
- o_def  output  DEF_W  data field
- o_err  output  1  marker mismatch in the presented frame
- o_errCount  output  8  saturating count of errored frames

## Operation
- Frame layout, MSB to LSB, right-aligned in NBEATS*IN_W bits: pad zeros (NBEATS*IN_W - DEF_W - 29 bits), abc[0], 12'h345, def[DEF_W-1:0], 16'h3456.
- Pad bits are ignored and not checked.
- Beat accepted when i_valid && o_ready. The beat shifts into a NBEATS*IN_W shift register from the LSB end; the beat counter increments.
- FSM:
  - COLLECT: o_ready=1, o_valid=0. On acceptance of beat NBEATS-1 (counter == NBEATS-1): latch o_abc/o_def, set o_err = (marker12 != 12'h345) || (marker16 != 16'h3456), clear counter, go to PRESENT.
  - PRESENT: o_ready=0, o_valid=1, outputs stable. On i_ready: go to COLLECT. o_valid drops the next cycle.
- o_err is set regardless of mismatch location. The errored frame is still delivered, with o_err=1.
- o_errCount increments by 1 on each transition into PRESENT with the error set. It saturates at 8'hFF; no wrap.
- Reset:
  - State goes to COLLECT; counter and shift register are cleared.
  - o_valid=0, o_ready=1 (combinational from state).
  - o_abc=0, o_def=0, o_err=0, o_errCount=0.
  - A partial frame in flight is discarded. Beats presented in the reset cycle are not accepted.
- i_valid low in COLLECT: nothing changes. Gaps between beats are allowed indefinitely.
- i_valid high during PRESENT: the beat is not accepted, because o_ready=0. The upstream holds it.

## Timing
- o_ready and o_valid are decoded from state registers only. There is no combinational path from i_valid or i_ready.
- Latency: final beat accepted at edge t, so o_valid=1 and fields are valid after t (visible in cycle t+1).
- Consumer ready in cycle t+1 means the handshake completes at edge t+1. o_ready=1 in cycle t+2, and the first beat of the next frame can be accepted at edge t+2.
- Peak throughput: one frame per NBEATS+1 cycles.
- o_abc, o_def, o_err hold their last value after the handshake until the next frame is latched.
- o_errCount updates on the same edge that raises o_valid.

## Test plan
- Good frame, abc=1, def=32'hDEADBEEF: beats 13 45 DE AD BE EF 34 56 on consecutive cycles, i_ready=1.
  - o_valid is high for exactly one cycle, starting the cycle after beat 56 is accepted.
  - o_abc=1, o_def=32'hDEADBEEF, o_err=0, o_errCount=0.
- Marker error: beats 03 46 DE AD BE EF 34 56.
  - o_abc=0, o_def=32'hDEADBEEF, o_err=1, o_errCount=1.
  - A following good frame gives o_err=0 with o_errCount still 1.
- Backpressure: good frame with i_ready=0 for 5 cycles and i_valid held high with the next frame's first beat.
  - o_valid stays high with stable fields; o_ready stays 0 and no beat is consumed.
  - After i_ready=1, the next frame decodes correctly.
- Gapped input: the 8 beats of the good frame with random i_valid gaps of 0-3 cycles produce an identical result to the first scenario.
- Reset mid-frame: 4 beats, then i_rst for 1 cycle, then a full good frame.
  - All outputs are at reset values in the cycle after reset.
  - The frame decodes correctly, with no residue from the partial frame.
- Saturation: 260 errored frames give o_errCount=8'hFF, and it stays 8'hFF after a further errored frame.
